// File: rtl/ebpf_shifter.sv
// rtl/ebpf_shifter.sv - iterative one-bit-per-clock LSH/RSH/ARSH unit with stb/ack handshake
module ebpf_shifter #(
    parameter int data_width = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stb,
    input  logic                  arith,
    input  logic                  left,
    input  logic [data_width-1:0] value,
    input  logic [data_width-1:0] shift,
    output logic [data_width-1:0] out,
    output logic                  ack
);

    localparam int sw = $clog2(data_width);
    localparam logic [sw-1:0] cnt_one = sw'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state, state_next;
    logic [data_width-1:0] acc, acc_next;
    logic [data_width-1:0] out_next;
    logic [sw-1:0]         cnt, cnt_next;
    logic                  mode_left, mode_left_next;
    logic                  mode_arith, mode_arith_next;
    logic                  ack_next;

    // eBPF masks the shift amount to log2(width) bits; the rest is deliberately dropped.
    logic unused_shift;
    assign unused_shift = ^shift[data_width-1:sw];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            mode_left  <= 1'b0;
            mode_arith <= 1'b0;
            out        <= '0;
            ack        <= 1'b0;
        end else begin
            state      <= state_next;
            acc        <= acc_next;
            cnt        <= cnt_next;
            mode_left  <= mode_left_next;
            mode_arith <= mode_arith_next;
            out        <= out_next;
            ack        <= ack_next;
        end
    end

    always_comb begin
        state_next      = state;
        acc_next        = acc;
        cnt_next        = cnt;
        mode_left_next  = mode_left;
        mode_arith_next = mode_arith;
        out_next        = out;
        ack_next        = 1'b0;
        case (state)
            IDLE: begin
                if (stb) begin
                    acc_next        = value;
                    cnt_next        = shift[sw-1:0];
                    mode_left_next  = left;
                    mode_arith_next = arith;
                    state_next      = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - cnt_one;
                    if (mode_left) begin
                        acc_next = {acc[data_width-2:0], 1'b0};
                    end else begin
                        acc_next = {mode_arith & acc[data_width-1], acc[data_width-1:1]};
                    end
                end else begin
                    // Result is published only here, so out never shows partial shifts.
                    out_next   = acc;
                    ack_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ebpf_shifter.sv
// tb/tb_ebpf_shifter.sv - scoreboard bench for ebpf_shifter
module tb_ebpf_shifter;

    localparam int DW = 64;
    localparam int SW = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0;
    logic          arith = 1'b0;
    logic          left = 1'b0;
    logic [DW-1:0] value = '0;
    logic [DW-1:0] shift = '0;
    logic [DW-1:0] out;
    logic          ack;

    always #5 clk = ~clk;

    ebpf_shifter #(.data_width(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stb   (stb),
        .arith (arith),
        .left  (left),
        .value (value),
        .shift (shift),
        .out   (out),
        .ack   (ack)
    );

    typedef struct {
        logic [DW-1:0] res;
        int            lat;
        int            issue;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    int            neg_cyc = 0;
    logic [DW-1:0] last_out = '0;

    // Scoreboard monitor: every ack pops one expectation.
    initial begin
        forever begin
            @(negedge clk);
            neg_cyc++;
            if (ack === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack out=%h required no ack", out);
                end else begin
                    mon_e = sb.pop_front();
                    checks++;
                    if (out !== mon_e.res) begin
                        errors++;
                        $display("FAIL result out=%h required=%h", out, mon_e.res);
                    end
                    checks++;
                    if ((neg_cyc - mon_e.issue) !== mon_e.lat) begin
                        errors++;
                        $display("FAIL latency got=%0d required=%0d", neg_cyc - mon_e.issue, mon_e.lat);
                    end
                    last_out = mon_e.res;
                end
            end
        end
    end

    function automatic logic [DW-1:0] model(input logic [DW-1:0] v, input logic [DW-1:0] s,
                                            input logic l, input logic a);
        logic [SW-1:0] n;
        n = s[SW-1:0];
        if (l) return v << n;
        if (a) return DW'($signed(v) >>> n);
        return v >> n;
    endfunction

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [DW-1:0] v, input logic [DW-1:0] s,
                            input logic l, input logic a, input logic [DW-1:0] expv);
        exp_t e;
        value = v;
        shift = s;
        left  = l;
        arith = a;
        stb   = 1'b1;
        e.res   = expv;
        e.lat   = int'(s[SW-1:0]) + 2;
        e.issue = neg_cyc;
        sb.push_back(e);
        sync();
        stb   = 1'b0;
        value = {$urandom, $urandom};
        shift = {$urandom, $urandom};
        left  = 1'($urandom);
        arith = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            sync();
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sync();
        checks++;
        if (out !== '0) begin errors++; $display("FAIL reset_out out=%h required=0", out); end
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack ack=%b required=0", ack); end
        rst_n = 1'b1;
        repeat (3) sync();
        checks++;
        if (ack !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL idle_after_reset ack=%b out=%h required ack=0 out=0", ack, out);
        end
    endtask

    task automatic test_right();
        drive_op(64'h1000, 64'd1, 1'b0, 1'b1, 64'h0000_0000_0000_0800);
        wait_done("rsh_1000");
        drive_op(64'h1, 64'd1, 1'b0, 1'b1, 64'h0);
        wait_done("rsh_1");
        drive_op(64'h8000_0000_0000_0080, 64'd4, 1'b0, 1'b1, 64'hF800_0000_0000_0008);
        wait_done("arsh_4");
        drive_op(64'h8000_0000_0000_0080, 64'd4, 1'b0, 1'b0, 64'h0800_0000_0000_0008);
        wait_done("rsh_4");
    endtask

    task automatic test_long_right();
        drive_op(64'h8000_0000_0000_0000, 64'd60, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (20) sync();
        checks++;
        if (out !== last_out || ack !== 1'b0) begin
            errors++;
            $display("FAIL hold_mid_op out=%h ack=%b required out=%h ack=0", out, ack, last_out);
        end
        wait_done("arsh_60");
        drive_op(64'h8000_0000_0000_0000, 64'd60, 1'b0, 1'b0, 64'h8);
        wait_done("rsh_60");
    endtask

    task automatic test_left();
        drive_op(64'h1, 64'd63, 1'b1, 1'b1, 64'h8000_0000_0000_0000);
        wait_done("lsh_63");
        drive_op(64'h1, 64'd64, 1'b1, 1'b1, 64'h1);
        wait_done("lsh_64_masked");
        drive_op(64'hA5A5_0000_1234_5678, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 1'b1, 64'hA5A5_0000_1234_5678);
        wait_done("rsh_masked_zero");
    endtask

    task automatic test_random();
        logic [DW-1:0] v, s;
        logic          l, a;
        for (int i = 0; i < 10; i++) begin
            v = {$urandom, $urandom};
            s = {$urandom, $urandom};
            l = 1'($urandom);
            a = 1'($urandom);
            drive_op(v, s, l, a, model(v, s, l, a));
            wait_done("random");
        end
    endtask

    task automatic test_ignore_stb();
        logic [DW-1:0] v;
        v = 64'hDEAD_BEEF_0123_4567;
        drive_op(v, 64'd40, 1'b0, 1'b1, model(v, 64'd40, 1'b0, 1'b1));
        repeat (10) sync();
        value = 64'h1111_2222_3333_4444;
        shift = 64'd3;
        left  = 1'b1;
        stb   = 1'b1;
        sync();
        stb = 1'b0;
        checks++;
        if (out !== last_out) begin
            errors++;
            $display("FAIL ignore_stb_hold out=%h required=%h", out, last_out);
        end
        wait_done("ignore_stb");
        repeat (10) sync();
    endtask

    task automatic test_reset_abort();
        drive_op(64'h0F0F_0000_FFFF_1234, 64'd40, 1'b1, 1'b0, 64'h0);
        repeat (10) sync();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== '0 || ack !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset out=%h ack=%b required out=0 ack=0", out, ack);
        end
        sb.delete();
        last_out = '0;
        sync();
        rst_n = 1'b1;
        repeat (50) sync();
        checks++;
        if (out !== '0) begin
            errors++;
            $display("FAIL abort_no_update out=%h required=0", out);
        end
        drive_op(64'h0000_0000_00F0_0000, 64'd8, 1'b0, 1'b0, 64'h0000_0000_0000_F000);
        wait_done("after_abort");
    endtask

    task automatic test_back_to_back();
        int k;
        drive_op(64'h3, 64'd2, 1'b1, 1'b0, 64'hC);
        k = 0;
        while (ack !== 1'b1 && k < 80) begin sync(); k++; end
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 ack=%b required=1", ack); end
        drive_op(64'h7777_0000_0000_0001, 64'd0, 1'b0, 1'b1, 64'h7777_0000_0000_0001);
        k = 0;
        while (ack !== 1'b1 && k < 80) begin sync(); k++; end
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 ack=%b required=1", ack); end
        drive_op(64'hF000_0000_0000_0000, 64'd5, 1'b0, 1'b1, 64'hFF80_0000_0000_0000);
        wait_done("b2b");
        repeat (5) sync();
    endtask

    initial begin
        test_reset();
        test_right();
        test_long_right();
        test_left();
        test_random();
        test_ignore_stb();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
